// File: rtl/irs_block_allocator_pkg.sv
// rtl/irs_block_allocator_pkg.sv - shared types and defaults for the IRS block allocator
package irs_block_allocator_pkg;

    localparam int NUM_BLOCKS_DEF  = 128;
    localparam int BLOCK_BITS_DEF  = 7;
    localparam int MAX_TRIG_BLOCKS = 15;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ALLOC = 2'd2
    } alloc_state_t;

    function automatic int clogb2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    localparam int NBLK_BITS = clogb2(MAX_TRIG_BLOCKS + 1);

endpackage

// File: rtl/irs_block_allocator_if.sv
// rtl/irs_block_allocator_if.sv - trigger, grant and return signals of the block allocator
interface irs_block_allocator_if #(
    parameter int BLOCK_BITS = irs_block_allocator_pkg::BLOCK_BITS_DEF
);
    import irs_block_allocator_pkg::*;

    logic                  trig_i;
    logic [NBLK_BITS-1:0]  trig_nblocks_i;
    logic                  dead_i;
    logic                  block_req_o;
    logic [BLOCK_BITS-1:0] block_addr_o;
    logic                  done_valid_i;
    logic [BLOCK_BITS-1:0] done_addr_i;
    logic                  block_done_o;
    logic                  trig_dropped_o;
    logic                  err_o;
    logic [BLOCK_BITS:0]   free_count_o;
    logic                  busy_o;

    modport master (
        output trig_i, trig_nblocks_i, dead_i, done_valid_i, done_addr_i,
        input  block_req_o, block_addr_o, block_done_o, trig_dropped_o, err_o, free_count_o, busy_o
    );

    modport slave (
        input  trig_i, trig_nblocks_i, dead_i, done_valid_i, done_addr_i,
        output block_req_o, block_addr_o, block_done_o, trig_dropped_o, err_o, free_count_o, busy_o
    );

endinterface

// File: rtl/irs_free_list_fifo.sv
// rtl/irs_free_list_fifo.sv - free-list FIFO of block addresses, head readable combinationally
module irs_free_list_fifo
    import irs_block_allocator_pkg::*;
#(
    parameter int DEPTH = NUM_BLOCKS_DEF,
    parameter int WIDTH = clogb2(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head,
    output logic [clogb2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full
);
    localparam int AW = clogb2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/irs_block_allocator.sv
// rtl/irs_block_allocator.sv - grants IRS storage blocks per trigger and reclaims them after readout
module irs_block_allocator
    import irs_block_allocator_pkg::*;
#(
    parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
    parameter int BLOCK_BITS = clogb2(NUM_BLOCKS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    irs_block_allocator_if.slave bus
);
    alloc_state_t          state_q, state_d;
    logic [BLOCK_BITS-1:0] init_cnt_q, fifo_wdata, fifo_head;
    logic [BLOCK_BITS:0]   fifo_count;
    logic [NBLK_BITS-1:0]  remain_q;
    logic fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic trig_zero, trig_ok, ret_ok, ret_err, init_last, alloc_last;
    logic dropped_q, done_q, err_q, busy_q;

    assign init_last  = (init_cnt_q == BLOCK_BITS'(NUM_BLOCKS - 1));
    assign alloc_last = (remain_q == NBLK_BITS'(1));
    assign trig_zero  = bus.trig_i && (state_q == ST_IDLE) && (bus.trig_nblocks_i == '0);
    // Grants are all-or-nothing: a trigger wanting more than is free is refused outright.
    assign trig_ok    = bus.trig_i && (state_q == ST_IDLE) && !bus.dead_i && !trig_zero
                        && ((BLOCK_BITS+1)'(bus.trig_nblocks_i) <= fifo_count);
    assign ret_ok     = bus.done_valid_i && (state_q != ST_INIT) && !fifo_full;
    assign ret_err    = bus.done_valid_i && !ret_ok;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (init_last)  state_d = ST_IDLE;
            ST_IDLE:  if (trig_ok)    state_d = ST_ALLOC;
            ST_ALLOC: if (alloc_last) state_d = ST_IDLE;
            default:                  state_d = ST_INIT;
        endcase
    end

    // Pop in ALLOC and push of returns share the FIFO; a pushed address lands at the tail.
    always_comb begin
        bus.block_req_o  = 1'b0;
        bus.block_addr_o = '0;
        fifo_pop         = 1'b0;
        fifo_push        = ret_ok;
        fifo_wdata       = bus.done_addr_i;
        case (state_q)
            ST_INIT: begin
                fifo_push  = 1'b1;
                fifo_wdata = init_cnt_q;
            end
            ST_ALLOC: begin
                fifo_pop         = !fifo_empty;
                bus.block_req_o  = !fifo_empty;
                bus.block_addr_o = fifo_head;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            init_cnt_q <= '0;
            remain_q   <= '0;
            dropped_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + BLOCK_BITS'(1);
            if (trig_ok)                  remain_q <= bus.trig_nblocks_i;
            else if (state_q == ST_ALLOC) remain_q <= remain_q - NBLK_BITS'(1);
            dropped_q <= bus.trig_i && !trig_ok;
            done_q    <= ret_ok;
            err_q     <= err_q | trig_zero | ret_err;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign bus.trig_dropped_o = dropped_q;
    assign bus.block_done_o   = done_q;
    assign bus.err_o          = err_q;
    assign bus.busy_o         = busy_q;
    assign bus.free_count_o   = fifo_count;

    irs_free_list_fifo #(
        .DEPTH (NUM_BLOCKS),
        .WIDTH (BLOCK_BITS)
    ) u_free_list (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_irs_block_allocator.sv
// tb/tb_irs_block_allocator.sv - self-checking bench for irs_block_allocator against a queue model
module tb_irs_block_allocator;
    localparam int NB = 128;
    localparam int BB = 7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    irs_block_allocator_if #(.BLOCK_BITS(BB)) bus ();

    irs_block_allocator #(.NUM_BLOCKS(NB), .BLOCK_BITS(BB)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: free list and outstanding set as queues, plus grants still owed and init writes left.
    int fl[$];
    int out_q[$];
    int init_left, pending;
    bit m_err;
    logic          exp_req, exp_done, exp_drop, exp_err, exp_busy;
    logic [BB-1:0] exp_addr;
    logic [BB:0]   exp_count;

    task automatic clear_inputs();
        bus.trig_i = 1'b0; bus.trig_nblocks_i = '0; bus.dead_i = 1'b0;
        bus.done_valid_i = 1'b0; bus.done_addr_i = '0;
    endtask

    task automatic model_reset();
        fl.delete(); out_q.delete();
        init_left = NB; pending = 0; m_err = 1'b0;
        exp_req = 0; exp_done = 0; exp_drop = 0; exp_err = 0; exp_busy = 0; exp_addr = '0; exp_count = '0;
    endtask

    task automatic set_trig(input int n, input bit dead);
        bus.trig_i = 1'b1; bus.trig_nblocks_i = 4'(n); bus.dead_i = dead;
    endtask

    task automatic ret_addr(input int a);
        for (int i = 0; i < out_q.size(); i++) if (out_q[i] == a) begin out_q.delete(i); break; end
        bus.done_valid_i = 1'b1; bus.done_addr_i = BB'(a);
    endtask

    task automatic ret_random(output int a);
        int idx;
        idx = $urandom_range(0, out_q.size() - 1);
        a = out_q[idx];
        ret_addr(a);
    endtask

    // Applies this cycle's inputs to the model, clocks once, and leaves expectations for the new cycle.
    task automatic tick();
        bit do_ret, do_acc;
        int nb;
        nb = int'(bus.trig_nblocks_i);
        do_ret = 0; do_acc = 0; exp_drop = 0;
        if (init_left > 0) begin
            if (bus.trig_i) exp_drop = 1;
            if (bus.done_valid_i) m_err = 1;
        end else begin
            if (bus.done_valid_i) begin
                if (fl.size() == NB) m_err = 1; else do_ret = 1;
            end
            if (bus.trig_i) begin
                if (pending == 0 && nb == 0) m_err = 1;
                if (pending > 0 || bus.dead_i || nb == 0 || nb > fl.size()) exp_drop = 1;
                else do_acc = 1;
            end
        end
        if (pending > 0) begin out_q.push_back(fl.pop_front()); pending--; end
        if (do_ret) fl.push_back(int'(bus.done_addr_i));
        if (init_left > 0) begin fl.push_back(NB - init_left); init_left--; end
        if (do_acc) pending = nb;
        exp_done = do_ret;
        @(posedge clk); #1;
        clear_inputs();
        exp_req   = (pending > 0);
        exp_addr  = exp_req ? BB'(fl[0]) : '0;
        exp_count = (BB+1)'(fl.size());
        exp_busy  = (init_left > 0) || (pending > 0);
        exp_err   = m_err;
    endtask

    task automatic test_reset();
        clear_inputs(); model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        n_checks++; if (bus.block_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0b want 0", bus.block_req_o); end
        n_checks++; if (bus.block_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", bus.block_done_o); end
        n_checks++; if (bus.trig_dropped_o !== 1'b0) begin n_fail++; $display("FAIL reset_drop got %0b want 0", bus.trig_dropped_o); end
        n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b want 0", bus.err_o); end
        n_checks++; if (bus.free_count_o !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.free_count_o); end
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy_o); end
    endtask

    task automatic test_init();
        rst_n = 1'b1;
        for (int k = 1; k <= NB; k++) begin
            tick();
            n_checks++; if (bus.free_count_o !== (BB+1)'(k)) begin n_fail++; $display("FAIL init_count k=%0d got %0d want %0d", k, bus.free_count_o, k); end
            n_checks++; if (bus.busy_o !== (k < NB)) begin n_fail++; $display("FAIL init_busy k=%0d got %0b want %0b", k, bus.busy_o, k < NB); end
            n_checks++; if ({bus.block_req_o, bus.block_done_o, bus.trig_dropped_o} !== 3'b000) begin n_fail++; $display("FAIL init_strobes k=%0d got %b want 000", k, {bus.block_req_o, bus.block_done_o, bus.trig_dropped_o}); end
        end
    endtask

    task automatic test_alloc_basic();
        set_trig(4, 0); tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.block_req_o !== 1'b1) begin n_fail++; $display("FAIL basic_req i=%0d got %0b want 1", i, bus.block_req_o); end
            n_checks++; if (bus.block_addr_o !== BB'(i)) begin n_fail++; $display("FAIL basic_addr i=%0d got %0d want %0d", i, bus.block_addr_o, i); end
            tick();
        end
        n_checks++; if (bus.block_req_o !== 1'b0) begin n_fail++; $display("FAIL basic_end_req got %0b want 0", bus.block_req_o); end
        n_checks++; if (bus.free_count_o !== 8'd124) begin n_fail++; $display("FAIL basic_count got %0d want 124", bus.free_count_o); end
    endtask

    task automatic test_returns_and_drain();
        int last1, last2, n;
        ret_addr(2); tick();
        n_checks++; if (bus.block_done_o !== 1'b1) begin n_fail++; $display("FAIL ret2_done got %0b want 1", bus.block_done_o); end
        tick();
        n_checks++; if (bus.block_done_o !== 1'b0) begin n_fail++; $display("FAIL ret2_done_clear got %0b want 0", bus.block_done_o); end
        ret_addr(0); tick();
        n_checks++; if (bus.block_done_o !== 1'b1) begin n_fail++; $display("FAIL ret0_done got %0b want 1", bus.block_done_o); end
        n_checks++; if (bus.free_count_o !== 8'd126) begin n_fail++; $display("FAIL ret_count got %0d want 126", bus.free_count_o); end
        tick();
        last1 = -1; last2 = -1;
        while (fl.size() > 0) begin
            n = (fl.size() > 15) ? 15 : fl.size();
            set_trig(n, 0); tick();
            for (int i = 0; i < n; i++) begin
                n_checks++; if (bus.block_req_o !== 1'b1 || bus.block_addr_o !== exp_addr) begin n_fail++; $display("FAIL drain_grant got req=%0b addr=%0d want req=1 addr=%0d", bus.block_req_o, bus.block_addr_o, exp_addr); end
                last2 = last1; last1 = int'(bus.block_addr_o);
                tick();
            end
        end
        n_checks++; if (last2 !== 2 || last1 !== 0) begin n_fail++; $display("FAIL drain_order got %0d,%0d want 2,0", last2, last1); end
        n_checks++; if (bus.free_count_o !== '0) begin n_fail++; $display("FAIL drain_count got %0d want 0", bus.free_count_o); end
    endtask

    task automatic test_drops();
        int a;
        for (int i = 0; i < 3; i++) begin
            ret_random(a); tick();
            n_checks++; if (bus.block_done_o !== 1'b1) begin n_fail++; $display("FAIL drops_ret_done i=%0d got %0b want 1", i, bus.block_done_o); end
        end
        set_trig(2, 1); tick();
        n_checks++; if (bus.trig_dropped_o !== 1'b1 || bus.block_req_o !== 1'b0) begin n_fail++; $display("FAIL dead_drop got drop=%0b req=%0b want drop=1 req=0", bus.trig_dropped_o, bus.block_req_o); end
        set_trig(4, 0); tick();
        n_checks++; if (bus.trig_dropped_o !== 1'b1 || bus.block_req_o !== 1'b0) begin n_fail++; $display("FAIL short_drop got drop=%0b req=%0b want drop=1 req=0", bus.trig_dropped_o, bus.block_req_o); end
        n_checks++; if (bus.free_count_o !== 8'd3) begin n_fail++; $display("FAIL short_count got %0d want 3", bus.free_count_o); end
        set_trig(1, 0); tick();
        n_checks++; if (bus.block_req_o !== 1'b1 || bus.trig_dropped_o !== 1'b0) begin n_fail++; $display("FAIL one_grant got req=%0b drop=%0b want req=1 drop=0", bus.block_req_o, bus.trig_dropped_o); end
        set_trig(1, 0); tick();
        n_checks++; if (bus.trig_dropped_o !== 1'b1 || bus.block_req_o !== 1'b0) begin n_fail++; $display("FAIL alloc_drop got drop=%0b req=%0b want drop=1 req=0", bus.trig_dropped_o, bus.block_req_o); end
        n_checks++; if (bus.free_count_o !== 8'd2) begin n_fail++; $display("FAIL alloc_drop_count got %0d want 2", bus.free_count_o); end
    endtask

    task automatic test_pop_push();
        int x, y;
        set_trig(2, 0); tick();
        bus.dead_i = 1'b1; tick();
        n_checks++; if (bus.block_req_o !== 1'b1) begin n_fail++; $display("FAIL dead_mid_alloc got req=%0b want 1", bus.block_req_o); end
        n_checks++; if (bus.free_count_o !== 8'd1) begin n_fail++; $display("FAIL pp_count_before got %0d want 1", bus.free_count_o); end
        y = int'(bus.block_addr_o);
        ret_random(x); tick();
        n_checks++; if (bus.free_count_o !== 8'd1 || bus.block_done_o !== 1'b1) begin n_fail++; $display("FAIL pp_count_after got count=%0d done=%0b want count=1 done=1", bus.free_count_o, bus.block_done_o); end
        n_checks++; if (y == x) begin n_fail++; $display("FAIL pp_same_cycle_grant got %0d want not %0d", y, x); end
        set_trig(1, 0); tick();
        n_checks++; if (bus.block_req_o !== 1'b1 || bus.block_addr_o !== BB'(x)) begin n_fail++; $display("FAIL pp_later_grant got req=%0b addr=%0d want req=1 addr=%0d", bus.block_req_o, bus.block_addr_o, x); end
        tick();
    endtask

    task automatic test_overflow();
        int a;
        while (out_q.size() > 0) begin
            ret_random(a); tick();
            n_checks++; if (bus.block_done_o !== 1'b1) begin n_fail++; $display("FAIL ov_fill_done got %0b want 1", bus.block_done_o); end
        end
        tick();
        n_checks++; if (bus.free_count_o !== 8'd128 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL ov_full got count=%0d err=%0b want count=128 err=0", bus.free_count_o, bus.err_o); end
        bus.done_valid_i = 1'b1; bus.done_addr_i = BB'(5); tick();
        n_checks++; if (bus.err_o !== 1'b1 || bus.block_done_o !== 1'b0) begin n_fail++; $display("FAIL ov_err got err=%0b done=%0b want err=1 done=0", bus.err_o, bus.block_done_o); end
        repeat (3) tick();
        n_checks++; if (bus.err_o !== 1'b1 || bus.free_count_o !== 8'd128) begin n_fail++; $display("FAIL ov_sticky got err=%0b count=%0d want err=1 count=128", bus.err_o, bus.free_count_o); end
    endtask

    task automatic test_reset_mid_alloc();
        set_trig(15, 0); tick(); tick();
        n_checks++; if (bus.block_req_o !== 1'b1) begin n_fail++; $display("FAIL mid_pre_req got %0b want 1", bus.block_req_o); end
        rst_n = 1'b0; #1;
        n_checks++; if ({bus.block_req_o, bus.busy_o, bus.err_o, bus.trig_dropped_o, bus.block_done_o} !== 5'b0) begin n_fail++; $display("FAIL mid_reset_outs got %b want 00000", {bus.block_req_o, bus.busy_o, bus.err_o, bus.trig_dropped_o, bus.block_done_o}); end
        n_checks++; if (bus.free_count_o !== '0) begin n_fail++; $display("FAIL mid_reset_count got %0d want 0", bus.free_count_o); end
        model_reset(); clear_inputs();
        @(posedge clk); #1; rst_n = 1'b1;
        for (int k = 1; k <= NB; k++) begin
            if (k == 10) set_trig(3, 0);
            tick();
            n_checks++; if (bus.trig_dropped_o !== (k == 10)) begin n_fail++; $display("FAIL reinit_drop k=%0d got %0b want %0b", k, bus.trig_dropped_o, k == 10); end
            n_checks++; if (bus.free_count_o !== (BB+1)'(k) || bus.busy_o !== (k < NB) || bus.block_req_o !== 1'b0) begin n_fail++; $display("FAIL reinit k=%0d got count=%0d busy=%0b req=%0b", k, bus.free_count_o, bus.busy_o, bus.block_req_o); end
        end
        set_trig(0, 0); tick();
        n_checks++; if (bus.trig_dropped_o !== 1'b1 || bus.err_o !== 1'b1 || bus.block_req_o !== 1'b0) begin n_fail++; $display("FAIL zero_nblocks got drop=%0b err=%0b req=%0b want 1,1,0", bus.trig_dropped_o, bus.err_o, bus.block_req_o); end
    endtask

    task automatic test_random();
        int a;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) set_trig($urandom_range(0, 15), $urandom_range(0, 4) == 0);
            if (out_q.size() > 0 && $urandom_range(0, 1) == 1) ret_random(a);
            tick();
            n_checks++; if (bus.block_req_o !== exp_req) begin n_fail++; $display("FAIL rnd_req c=%0d got %0b want %0b", c, bus.block_req_o, exp_req); end
            if (exp_req) begin
                n_checks++; if (bus.block_addr_o !== exp_addr) begin n_fail++; $display("FAIL rnd_addr c=%0d got %0d want %0d", c, bus.block_addr_o, exp_addr); end
            end
            n_checks++; if (bus.block_done_o !== exp_done) begin n_fail++; $display("FAIL rnd_done c=%0d got %0b want %0b", c, bus.block_done_o, exp_done); end
            n_checks++; if (bus.trig_dropped_o !== exp_drop) begin n_fail++; $display("FAIL rnd_drop c=%0d got %0b want %0b", c, bus.trig_dropped_o, exp_drop); end
            n_checks++; if (bus.free_count_o !== exp_count) begin n_fail++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, bus.free_count_o, exp_count); end
            n_checks++; if (bus.busy_o !== exp_busy) begin n_fail++; $display("FAIL rnd_busy c=%0d got %0b want %0b", c, bus.busy_o, exp_busy); end
            n_checks++; if (bus.err_o !== exp_err) begin n_fail++; $display("FAIL rnd_err c=%0d got %0b want %0b", c, bus.err_o, exp_err); end
        end
    endtask

    task automatic test_init_return();
        rst_n = 1'b0; clear_inputs(); model_reset();
        @(posedge clk); #1; rst_n = 1'b1;
        for (int k = 1; k <= NB; k++) begin
            if (k == 5) begin bus.done_valid_i = 1'b1; bus.done_addr_i = '0; end
            tick();
            n_checks++; if (bus.err_o !== (k >= 5) || bus.block_done_o !== 1'b0) begin n_fail++; $display("FAIL init_ret k=%0d got err=%0b done=%0b want err=%0b done=0", k, bus.err_o, bus.block_done_o, k >= 5); end
            n_checks++; if (bus.free_count_o !== (BB+1)'(k)) begin n_fail++; $display("FAIL init_ret_count k=%0d got %0d want %0d", k, bus.free_count_o, k); end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_alloc_basic();
        test_returns_and_drain();
        test_drops();
        test_pop_push();
        test_overflow();
        test_reset_mid_alloc();
        test_random();
        test_init_return();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irs_block_allocator.md
Name: irs_block_allocator

Overview:
- Issues IRS storage blocks to the trigger path and reclaims them after readout.
- Keeps a free-list FIFO of block addresses.
- For each accepted trigger, grants N blocks as single-cycle block_req_o pulses and reclaims each finished block as a block_done_o pulse.
- block_req_o and block_done_o drive the block-occupancy monitor's request/done inputs; its dead output returns here as dead_i to veto new triggers.

Parameters:
- NUM_BLOCKS, 128, number of free storage blocks managed; must be a power of two.
- BLOCK_BITS, 7, block address width; equals log2(NUM_BLOCKS).
- MAX_TRIG_BLOCKS, 15, largest legal per-trigger block count; 4-bit trig_nblocks_i.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-low reset.
- trig_i  in  1  trigger strobe, one cycle.
- trig_nblocks_i  in  4  blocks wanted by this trigger; sampled with trig_i; 0 is illegal.
- dead_i  in  1  veto from the occupancy monitor.
- block_req_o  out  1  one-cycle grant strobe.
- block_addr_o  out  BLOCK_BITS  granted block address; valid while block_req_o is high.
- done_valid_i  in  1  readout finished with a block.
- done_addr_i  in  BLOCK_BITS  address being returned.
- block_done_o  out  1  one-cycle strobe, one cycle after each accepted return.
- trig_dropped_o  out  1  one-cycle strobe when a trigger is refused.
- err_o  out  1  sticky error flag; cleared only by reset.
- free_count_o  out  BLOCK_BITS+1  current free-list occupancy.
- busy_o  out  1  high in INIT or ALLOC.

Behaviour:
- Reset (rst_i low, asynchronous):
  - State INIT; pointers 0; init counter 0; free count 0.
  - All outputs low/zero, including err_o.
- INIT state:
  - One write per cycle of address k, for k = 0..NUM_BLOCKS-1.
  - Enters IDLE after exactly NUM_BLOCKS cycles with free_count_o = NUM_BLOCKS.
  - trig_i during INIT: trig_dropped_o pulses.
  - done_valid_i during INIT: ignored; err_o set.
- IDLE state: trig_i is sampled. Dropped (trig_dropped_o next cycle, no grants, stay IDLE) if any of:
  - dead_i is high;
  - trig_nblocks_i = 0, which also sets err_o;
  - trig_nblocks_i > free count. Grants are never partial.
- Accept: otherwise latch n = trig_nblocks_i and go to ALLOC.
- ALLOC state:
  - Each cycle, pop the FIFO head; block_req_o = 1 and block_addr_o = head, for n consecutive cycles.
  - First grant is the cycle after trig_i.
  - Returns to IDLE after the nth grant; a new trigger is accepted on the first IDLE cycle.
  - trig_i during ALLOC: trig_dropped_o.
  - dead_i rising mid-ALLOC does not abort the burst.
- Free-list read: the FIFO is read combinationally from the head pointer, or registered RAM with a prefetch. Either way, grant timing above is fixed.
- Returns:
  - done_valid_i is accepted in IDLE and ALLOC; push done_addr_i; block_done_o the next cycle.
  - Return while free count = NUM_BLOCKS (overflow): ignored, err_o set, no block_done_o.
- Simultaneous pop and push in one cycle:
  - Both occur; free count unchanged.
  - A pushed address is never granted in the same cycle it is pushed, even when the FIFO is empty-but-one.
- Pointers are BLOCK_BITS wide and wrap modulo NUM_BLOCKS; the count is BLOCK_BITS+1 wide and never exceeds NUM_BLOCKS.
- Invariant: free count + outstanding blocks = NUM_BLOCKS, where outstanding = grants − block_done_o.
- Duplicate-address returns are not detected. The readout side guarantees each address returns once.

Decomposition:
- Shared package/header:
  - state encodings INIT/IDLE/ALLOC;
  - NUM_BLOCKS and BLOCK_BITS defaults;
  - clogb2 helper, already in the common include.
- One sub-module: irs_free_list_fifo. Synchronous FIFO with push/pop/count/empty/full, depth NUM_BLOCKS, width BLOCK_BITS, with simultaneous push+pop support.
- FSM, trigger qualification and error logic stay in the top.

Test Plan:
- Release reset, wait 128 cycles -> busy_o falls at cycle 128; free_count_o = 128; no strobes during INIT.
- trig_i with nblocks=4 in IDLE -> block_req_o high for 4 cycles starting next cycle, addresses 0,1,2,3; free_count_o = 124.
- Return addresses 2,0 -> block_done_o pulses 1 cycle after each; free_count_o = 126. Then allocate 124+2: a trig with nblocks=15 repeated until drained -> grants end with addresses 2 then 0, showing FIFO order.
- dead_i=1 with trig_i -> trig_dropped_o, no block_req_o. free_count_o = 3 with nblocks=4 -> dropped, count stays 3.
- Pop and push in the same cycle during ALLOC with free_count_o = 1 -> count stays 1; returned address granted only on a later cycle.
- Return with free_count_o = 128 -> err_o sticky high, no block_done_o. Reset low mid-ALLOC -> immediate return to INIT, outputs zero, re-init completes in 128 cycles.
